cla_adder: RTL and testbench
============================

Name: cla_adder

Overview:
- Width-parameterized carry-lookahead adder: A + B + carry-in → sum and carry-out.
- Default width is 4 bits.
- Lookahead carries are computed combinationally from per-bit generate/propagate terms; results are registered once.
- Sits in datapath arithmetic as a 1-cycle-latency adder with a simple valid qualifier.

Parameters:
- WIDTH, 4, operand/sum width in bits; must be a positive multiple of 4 (one lookahead group per 4 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- s  output  WIDTH  registered sum.
- cout  output  1  registered carry-out.
- out_valid  output  1  s/cout hold a fresh result.
- ovf  output  1  signed overflow; present only with CLA_OVF_EN.

Interface:
- One clock, clk. Reset is rst: synchronous and active-high (fixed).

Behaviour:
- Per bit i: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Carry chain: c[0] = cin; c[i+1] = g[i] | (p[i] & c[i]).
  - Within each 4-bit group, carries are expanded as flat sum-of-products (no ripple).
  - Group GG/GP terms are formed; group carry-ins come from the previous group's GG/GP and carry-in.
- Sum: s_next[i] = p[i] ^ c[i]; cout_next = c[WIDTH].
- Arithmetic: {cout_next, s_next} == a + b + cin exactly, computed as WIDTH+1 bits; no saturation.
- Registering:
  - On rising clk with rst=1: s←0, cout←0, out_valid←0, ovf←0.
  - Otherwise, if in_valid=1: s, cout (and ovf) load the new result; out_valid←1.
  - Otherwise, if in_valid=0: s, cout and ovf hold their previous values; out_valid←0.
- Latency: exactly 1 cycle from in_valid to out_valid. Back-to-back operands are accepted every cycle. No backpressure.
- rst asserted in the same cycle as in_valid: reset wins and the operands are dropped.
- Wrap-around: all-ones + all-ones + 1 gives s = all-ones, cout = 1. All-ones + 0 + 1 gives s = 0, cout = 1.
- Operand X values are not checked; behaviour is undefined.

Optional Feature:
- Macro: CLA_OVF_EN.
- Defined:
  - The ovf port exists.
  - ovf_next = c[WIDTH] ^ c[WIDTH-1] (two's-complement overflow).
  - ovf is registered with the same load/hold/reset rules as s.
- Undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package cla_pkg:
  - Constant GROUP_W = 4.
  - Function num_groups(WIDTH) = WIDTH / GROUP_W.
- Sub-module cla_group4:
  - Inputs: 4-bit a, 4-bit b, ci.
  - Outputs: 4-bit s, group generate gg, group propagate gp, co.
  - Purely combinational.
- cla_adder generates WIDTH/4 instances of cla_group4, links group carries by lookahead, and owns all registers.

Test Plan:
- Exhaustive, WIDTH=4: all 512 combinations of {cin, a, b}, one per cycle with in_valid=1 → one cycle later, {cout, s} == a + b + cin for every vector; out_valid=1 throughout.
- Boundaries: a=4'hF, b=4'h1, cin=0 → s=4'h0, cout=1. a=0, b=0, cin=1 → s=4'h1, cout=0. a=4'hF, b=4'hF, cin=1 → s=4'hF, cout=1.
- Hold: load a=4'h3, b=4'h4, cin=0 (s=4'h7); then drop in_valid and change operands → s stays 4'h7, cout stays 0, out_valid=0.
- Reset: rst=1 together with in_valid=1, a=4'h9, b=4'h9 → next cycle s=0, cout=0, out_valid=0. Deassert rst → normal results resume.
- Overflow, with CLA_OVF_EN: a=4'h7, b=4'h1, cin=0 → s=4'h8, ovf=1. a=4'h8, b=4'hF, cin=0 → s=4'h7, cout=1, ovf=1. a=4'h2, b=4'h3 → ovf=0.
- WIDTH=16: a=16'hFFFF, b=16'h0000, cin=1 → s=16'h0000, cout=1 (carry crosses all groups). 1000 random vectors match the reference sum.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package cla_pkg;

    localparam int unsigned GROUP_W = 4;

    function automatic int unsigned num_groups(input int unsigned width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: flat sum-of-products carries plus group generate/propagate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               gg,
    output logic               gp,
    output logic               co
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        // Every carry is expanded directly from g/p/ci so no carry waits on another.
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        co = gg | (gp & ci);

        s = p ^ c;
    end

endmodule

// File: rtl/cla_adder.sv
// Registered WIDTH-bit carry-lookahead adder, 1-cycle latency with valid qualifier.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NG = num_groups(WIDTH);

    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    co;
    logic [NG:1]      gc_la;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             out_valid_q;

    assign gc = {gc_la, cin};

    for (genvar j = 0; j < NG; j++) begin : g_group
        cla_group4 u_group (
            .a  (a[j*GROUP_W +: GROUP_W]),
            .b  (b[j*GROUP_W +: GROUP_W]),
            .ci (gc[j]),
            .s  (s_d[j*GROUP_W +: GROUP_W]),
            .gg (gg[j]),
            .gp (gp[j]),
            .co (co[j])
        );
    end

    // Second-level lookahead: each group carry-in is a flat OR of generate terms
    // propagated through the intervening groups, plus cin propagated through all of them.
    always_comb begin
        logic carry;
        logic term;
        carry = 1'b0;
        term  = 1'b0;
        gc_la = '0;
        for (int j = 0; j < int'(NG); j++) begin
            carry = 1'b0;
            for (int k = 0; k <= j; k++) begin
                term = gg[k];
                for (int m = k + 1; m <= j; m++) begin
                    term = term & gp[m];
                end
                carry = carry | term;
            end
            term = cin;
            for (int m = 0; m <= j; m++) begin
                term = term & gp[m];
            end
            gc_la[j+1] = carry | term;
        end
    end

    assign cout_d = gc[NG];

    // Each group's own carry-out must agree with the lookahead network.
    assert property (@(posedge clk) disable iff (rst) co == gc[NG:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
            end
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

`ifdef CLA_OVF_EN
    logic msb_cin;
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB recovered from the sum: s = a ^ b ^ c.
    assign msb_cin = a[WIDTH-1] ^ b[WIDTH-1] ^ s_d[WIDTH-1];
    assign ovf_d   = cout_d ^ msb_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder: a 4-bit and a 16-bit instance share one clock.
module tb_cla_adder;

    typedef struct packed {
        logic        v;
        logic        cout;
        logic [15:0] s;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4 = 1'b1, v4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [3:0]  s4;
    logic        cout4, ovalid4;
    logic        rst16 = 1'b1, v16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [15:0] s16;
    logic        cout16, ovalid16;
`ifdef CLA_OVF_EN
    logic        ovf4, ovf16;
`endif

    cla_adder #(.WIDTH(4)) dut4 (
`ifdef CLA_OVF_EN
        .ovf       (ovf4),
`endif
        .clk       (clk),
        .rst       (rst4),
        .in_valid  (v4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .s         (s4),
        .cout      (cout4),
        .out_valid (ovalid4)
    );

    cla_adder #(.WIDTH(16)) dut16 (
`ifdef CLA_OVF_EN
        .ovf       (ovf16),
`endif
        .clk       (clk),
        .rst       (rst16),
        .in_valid  (v16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .s         (s16),
        .cout      (cout16),
        .out_valid (ovalid16)
    );

    exp_t q4[$];
    exp_t q16[$];
    exp_t held4  = '0;
    exp_t held16 = '0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Stimulus side: drive on the falling edge and queue the state expected after the next rise.
    task automatic drive4(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic [4:0] sum, input logic ov);
        @(negedge clk);
        rst4 = r; v4 = v; a4 = a; b4 = b; cin4 = c;
        if (r) begin
            held4 = '0;
        end else if (v) begin
            held4.cout = sum[4];
            held4.s    = {12'h000, sum[3:0]};
            held4.ovf  = ov;
        end
        held4.v = v & ~r;
        q4.push_back(held4);
    endtask

    task automatic drive16(input logic r, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic c, input logic [16:0] sum,
                           input logic ov);
        @(negedge clk);
        rst16 = r; v16 = v; a16 = a; b16 = b; cin16 = c;
        if (r) begin
            held16 = '0;
        end else if (v) begin
            held16.cout = sum[16];
            held16.s    = sum[15:0];
            held16.ovf  = ov;
        end
        held16.v = v & ~r;
        q16.push_back(held16);
    endtask

    // Same-sign operands whose sum flips sign.
    function automatic logic sov(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the only process that touches the counters.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            cmp("w4 out_valid", 32'(ovalid4), 32'(e.v));
            cmp("w4 s", 32'(s4), 32'(e.s[3:0]));
            cmp("w4 cout", 32'(cout4), 32'(e.cout));
`ifdef CLA_OVF_EN
            cmp("w4 ovf", 32'(ovf4), 32'(e.ovf));
`endif
        end
        if (q16.size() > 0) begin
            e = q16.pop_front();
            cmp("w16 out_valid", 32'(ovalid16), 32'(e.v));
            cmp("w16 s", 32'(s16), 32'(e.s));
            cmp("w16 cout", 32'(cout16), 32'(e.cout));
`ifdef CLA_OVF_EN
            cmp("w16 ovf", 32'(ovf16), 32'(e.ovf));
`endif
        end
        if (done) begin
            cmp("w4 queue drained", 32'(q4.size()), 32'd0);
            cmp("w16 queue drained", 32'(q16.size()), 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [4:0]  sum4;
        logic [16:0] sum16;
        logic [15:0] ra, rb;
        logic        rc;

        // Reset state, then directed boundaries.
        drive4(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00, 1'b0);
        drive4(1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 5'h10, 1'b0);
        drive4(1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 5'h01, 1'b0);
        drive4(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 5'h1F, 1'b0);
        // Signed overflow cases.
        drive4(1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 5'h08, 1'b1);
        drive4(1'b0, 1'b1, 4'h8, 4'hF, 1'b0, 5'h17, 1'b1);
        drive4(1'b0, 1'b1, 4'h2, 4'h3, 1'b0, 5'h05, 1'b0);
        // Hold: outputs keep 3+4 while in_valid is low and operands move.
        drive4(1'b0, 1'b1, 4'h3, 4'h4, 1'b0, 5'h07, 1'b0);
        drive4(1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 5'h10, 1'b0);
        drive4(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 5'h1F, 1'b0);
        // Reset beats a simultaneous valid, then normal results resume.
        drive4(1'b1, 1'b1, 4'h9, 4'h9, 1'b0, 5'h12, 1'b1);
        drive4(1'b0, 1'b1, 4'h9, 4'h9, 1'b0, 5'h12, 1'b1);
        drive4(1'b0, 1'b1, 4'h6, 4'h5, 1'b1, 5'h0C, 1'b1);

        // Exhaustive 4-bit sweep, back-to-back.
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    sum4 = 5'(a) + 5'(b) + 5'(c);
                    drive4(1'b0, 1'b1, 4'(a), 4'(b), 1'(c), sum4,
                           sov(a[3], b[3], sum4[3]));
                end
            end
        end
        drive4(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00, 1'b0);

        // 16-bit: carry through every group, MSB overflow, then random vectors.
        drive16(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0);
        drive16(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b0);
        drive16(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
        drive16(1'b0, 1'b1, 16'h0FFF, 16'h0001, 1'b0, 17'h01000, 1'b0);
        drive16(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 1'($urandom);
            sum16 = 17'(ra) + 17'(rb) + 17'(rc);
            drive16(1'b0, 1'b1, ra, rb, rc, sum16, sov(ra[15], rb[15], sum16[15]));
        end
        drive16(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0);

        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
    end

endmodule
